// File: rtl/snake_input_ctrl.sv
// Snake game player-input front end: synchronizes and debounces five buttons,
// turns debounced presses into a direction code and a start pulse.
module snake_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  input  logic [1:0] game_state,
  output logic [1:0] direction,
  output logic       start,
  output logic       dir_reject
);

  localparam int unsigned NB = 5;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam int unsigned B_UP    = 0;
  localparam int unsigned B_DOWN  = 1;
  localparam int unsigned B_LEFT  = 2;
  localparam int unsigned B_RIGHT = 3;
  localparam int unsigned B_START = 4;

  typedef enum logic [1:0] {
    GS_IDLE    = 2'b00,
    GS_PLAYING = 2'b01,
    GS_OVER    = 2'b10,
    GS_RSVD    = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] s1;
  logic [NB-1:0] s2;
  logic [NB-1:0] stable;
  logic [CW-1:0] cnt [NB];
  logic [NB-1:0] press;

  dir_t        dir_q;
  dir_t        dir_next;
  dir_t        cand;
  logic        cand_valid;
  logic        start_next;
  logic        rej_next;
  logic        playing;
  logic [1:0]  cand_bits;
  logic [1:0]  cur_bits;
  game_state_t gs;

  assign raw = {btn_start, btn_right, btn_left, btn_down, btn_up};
  assign gs  = game_state_t'(game_state);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int unsigned i = 0; i < NB; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press is decoded from the same condition that flips stable 0->1, so the
  // registered outputs land on the very edge stable rises.
  always_comb begin
    for (int unsigned i = 0; i < NB; i++)
      press[i] = s2[i] & ~stable[i] & (cnt[i] == LAST);
  end

  always_comb begin
    cand       = dir_q;
    cand_valid = 1'b0;
    if (press[B_UP]) begin
      cand = DIR_UP;    cand_valid = 1'b1;
    end else if (press[B_DOWN]) begin
      cand = DIR_DOWN;  cand_valid = 1'b1;
    end else if (press[B_LEFT]) begin
      cand = DIR_LEFT;  cand_valid = 1'b1;
    end else if (press[B_RIGHT]) begin
      cand = DIR_RIGHT; cand_valid = 1'b1;
    end
  end

  always_comb begin
    dir_next   = dir_q;
    start_next = 1'b0;
    rej_next   = 1'b0;
    playing    = (gs == GS_PLAYING);
    cand_bits  = cand;
    cur_bits   = dir_q;
    if (press[B_START] && !playing) begin
      start_next = 1'b1;
      dir_next   = DIR_RIGHT;
    end else if (playing && cand_valid && (cand != dir_q)) begin
      if ((cand_bits[1] == cur_bits[1]) && (cand_bits[0] != cur_bits[0]))
        rej_next = 1'b1;
      else
        dir_next = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q      <= DIR_RIGHT;
      start      <= 1'b0;
      dir_reject <= 1'b0;
    end else begin
      dir_q      <= dir_next;
      start      <= start_next;
      dir_reject <= rej_next;
    end
  end

  assign direction = dir_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Scoreboard bench for snake_input_ctrl: a window-based reference model
// predicts output events, a monitor matches them against the DUT.
module tb_snake_input_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
  logic [1:0] game_state = 2'b00;
  logic [1:0] direction;
  logic       start;
  logic       dir_reject;

  snake_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_start  (btn_start),
    .game_state (game_state),
    .direction  (direction),
    .start      (start),
    .dir_reject (dir_reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         st;
    bit         rj;
    logic [1:0] dir;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  drv_cyc = 0;
  int  mcyc = 0;

  // Reference model state: sync samples, debounced level, sample windows.
  bit         m_s1[5];
  bit         m_s2[5];
  bit         m_stable[5];
  bit         hist[5][$];
  logic [1:0] m_dir = 2'b11;
  logic [1:0] opp[4] = '{2'b01, 2'b00, 2'b11, 2'b10};

  task automatic model_edge(input logic [4:0] raw, input logic [1:0] gs, input bit rst);
    bit         press[5];
    bit         st = 0;
    bit         rj = 0;
    bit         all;
    logic [1:0] nd = m_dir;
    if (rst) begin
      for (int b = 0; b < 5; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_stable[b] = 0; hist[b].delete();
      end
      nd = 2'b11;
    end else begin
      for (int b = 0; b < 5; b++) begin
        press[b] = 0;
        hist[b].push_back(m_s2[b]);
        if (hist[b].size() > D) void'(hist[b].pop_front());
        if (hist[b].size() == D) begin
          all = 1;
          for (int k = 0; k < D; k++) if (hist[b][k] == m_stable[b]) all = 0;
          if (all) begin
            m_stable[b] = ~m_stable[b];
            press[b] = m_stable[b];
          end
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
      if (press[4] && gs != 2'b01) begin
        st = 1;
        nd = 2'b11;
      end else if (gs == 2'b01) begin
        for (int b = 0; b < 4; b++) begin
          if (press[b]) begin
            if (2'(b) == m_dir) ;
            else if (2'(b) == opp[m_dir]) rj = 1;
            else nd = 2'(b);
            break;
          end
        end
      end
    end
    if (st || rj || nd != m_dir) q.push_back(ev_t'{drv_cyc, st, rj, nd});
    m_dir = nd;
  endtask

  task automatic step(input logic [4:0] m, input logic [1:0] gs, input bit rst);
    {btn_start, btn_right, btn_left, btn_down, btn_up} = m;
    game_state = gs;
    reset = rst;
    drv_cyc++;
    model_edge(m, gs, rst);
    @(negedge clk);
  endtask

  task automatic press(input logic [4:0] m, input logic [1:0] gs, input int hold);
    for (int i = 0; i < hold; i++) step(m, gs, 0);
    for (int i = 0; i < D + 4; i++) step(5'b0, gs, 0);
  endtask

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b required=%b", name, got, exp);
    end
  endtask

  // Monitor: every cycle the DUT shows an event, it must match the queue head.
  initial begin
    logic [1:0] prev;
    ev_t        e;
    prev = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      while (q.size() > 0 && q[0].cyc < mcyc) begin
        checks++; errors++;
        $display("FAIL missed_event cyc=%0d required start=%0b rej=%0b dir=%b",
                 q[0].cyc, q[0].st, q[0].rj, q[0].dir);
        void'(q.pop_front());
      end
      if (start !== 1'b0 || dir_reject !== 1'b0 || direction !== prev) begin
        checks++;
        if (q.size() == 0 || q[0].cyc != mcyc) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got start=%b rej=%b dir=%b required no event",
                   mcyc, start, dir_reject, direction);
        end else begin
          e = q.pop_front();
          if (start !== e.st || dir_reject !== e.rj || direction !== e.dir) begin
            errors++;
            $display("FAIL event cyc=%0d got start=%b rej=%b dir=%b required start=%0b rej=%0b dir=%b",
                     mcyc, start, dir_reject, direction, e.st, e.rj, e.dir);
          end
        end
      end
      prev = direction;
    end
  end

  initial begin
    logic [4:0] lv;
    logic [1:0] gs;
    bit         rst;

    step(5'b0, 2'b01, 1);
    step(5'b0, 2'b01, 1);
    chk("reset_direction", direction, 2'b11);
    chk("reset_start", {1'b0, start}, 2'b00);
    chk("reset_dir_reject", {1'b0, dir_reject}, 2'b00);

    step(5'b00001, 2'b01, 1);
    step(5'b00001, 2'b01, 1);
    for (int i = 0; i < D + 1; i++) step(5'b00001, 2'b01, 0);
    chk("up_during_reset_early", direction, 2'b11);
    step(5'b00001, 2'b01, 0);
    chk("up_after_reset_latency", direction, 2'b00);
    for (int i = 0; i < D + 4; i++) step(5'b0, 2'b01, 0);

    press(5'b10000, 2'b00, 20);
    chk("start_idle_heading", direction, 2'b11);
    press(5'b10000, 2'b01, 20);

    press(5'b00001, 2'b01, 10);
    chk("up_playing", direction, 2'b00);
    step(5'b00100, 2'b01, 0);
    step(5'b00000, 2'b01, 0);
    step(5'b00100, 2'b01, 0);
    step(5'b00100, 2'b01, 0);
    step(5'b00000, 2'b01, 0);
    chk("bounce_no_change", direction, 2'b00);
    press(5'b00100, 2'b01, 12);
    chk("bounce_settled_left", direction, 2'b10);

    press(5'b10000, 2'b00, 10);
    press(5'b00100, 2'b01, 10);
    chk("reversal_left_rejected", direction, 2'b11);
    press(5'b00001, 2'b01, 10);
    chk("reversal_up_accepted", direction, 2'b00);
    press(5'b00010, 2'b01, 10);
    chk("reversal_down_rejected", direction, 2'b00);

    press(5'b10000, 2'b00, 10);
    press(5'b00011, 2'b01, 10);
    chk("priority_up_over_down", direction, 2'b00);
    press(5'b00010, 2'b01, 10);
    chk("priority_down_rejected", direction, 2'b00);

    press(5'b10010, 2'b10, 10);
    chk("gameover_start_heading", direction, 2'b11);

    lv = '0;
    gs = 2'b01;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(7) == 0) lv[b] = ~lv[b];
      if ($urandom_range(39) == 0) gs = ($urandom_range(1) == 1) ? 2'b01 : 2'($urandom_range(3));
      rst = ($urandom_range(299) == 0);
      step(lv, gs, rst);
    end
    for (int i = 0; i < 2 * D + 8; i++) step(5'b0, gs, 0);

    while (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL leftover_event cyc=%0d required start=%0b rej=%0b dir=%b",
               q[0].cyc, q[0].st, q[0].rj, q[0].dir);
      void'(q.pop_front());
    end
    chk("final_direction_matches_model", direction, m_dir);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
